// File: rtl/nx_msg_router.sv
// nx_msg_router
//   Per-node message router. Each inbound message carries a target
//   (row, col) and a command in its MSBs:
//   - Messages addressed elsewhere go into a small bypass FIFO, tagged with
//     an outbound direction.
//   - Messages addressed to this node are decoded into one of three
//     registered output groups (instr, map or signal). Reserved commands
//     are counted as drops.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   node_row_i, node_col_i       this node's coordinates
//   msg_data_i/valid_i/ready_o   inbound valid/ready stream
//   bypass_data_o/dir_o/valid_o, bypass_ready_i
//                                outbound FIFO head plus direction (0=N 1=E 2=S 3=W)
//   map_*_o                      decoded MAP command fields plus a one-cycle map_valid_o
//   signal_*_o                   decoded SIGNAL command fields plus a one-cycle signal_valid_o
//   instr_core_o/data_o/valid_o  decoded INSTR command
//   drop_count_o                 saturating count of reserved-command messages
module nx_msg_router #(
    parameter int STREAM_WIDTH   = 32,
    parameter int ADDR_ROW_WIDTH = 4,
    parameter int ADDR_COL_WIDTH = 4,
    parameter int COMMAND_WIDTH  = 2,
    parameter int INSTR_WIDTH    = 15,
    parameter int INPUTS         = 8,
    parameter int OUTPUTS        = 8,
    parameter int CORES          = 2,
    parameter int BYPASS_DEPTH   = 2,
    localparam int MAX_IO = (INPUTS > OUTPUTS) ? INPUTS : OUTPUTS,
    localparam int IO_W   = (MAX_IO > 1) ? $clog2(MAX_IO) : 1,
    localparam int IDX_W  = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1,
    localparam int CORE_W = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [ADDR_ROW_WIDTH-1:0] node_row_i,
    input  logic [ADDR_COL_WIDTH-1:0] node_col_i,
    input  logic [STREAM_WIDTH-1:0]   msg_data_i,
    input  logic                      msg_valid_i,
    output logic                      msg_ready_o,
    output logic [STREAM_WIDTH-1:0]   bypass_data_o,
    output logic [1:0]                bypass_dir_o,
    output logic                      bypass_valid_o,
    input  logic                      bypass_ready_i,
    output logic [IO_W-1:0]           map_io_o,
    output logic                      map_input_o,
    output logic [ADDR_ROW_WIDTH-1:0] map_remote_row_o,
    output logic [ADDR_COL_WIDTH-1:0] map_remote_col_o,
    output logic [IDX_W-1:0]          map_remote_idx_o,
    output logic                      map_slot_o,
    output logic                      map_broadcast_o,
    output logic                      map_seq_o,
    output logic                      map_valid_o,
    output logic [ADDR_ROW_WIDTH-1:0] signal_remote_row_o,
    output logic [ADDR_COL_WIDTH-1:0] signal_remote_col_o,
    output logic [IDX_W-1:0]          signal_remote_idx_o,
    output logic                      signal_state_o,
    output logic                      signal_valid_o,
    output logic [CORE_W-1:0]         instr_core_o,
    output logic [INSTR_WIDTH-1:0]    instr_data_o,
    output logic                      instr_valid_o,
    output logic [7:0]                drop_count_o
);

    localparam int R  = ADDR_ROW_WIDTH;
    localparam int C  = ADDR_COL_WIDTH;
    localparam int PW = STREAM_WIDTH - R - C - COMMAND_WIDTH;

    localparam int INSTR_BITS = CORE_W + INSTR_WIDTH;
    localparam int MAP_BITS   = IO_W + 1 + R + C + IDX_W + 3;
    localparam int SIG_BITS   = R + C + IDX_W + 1;

    // Payload field offsets, LSB-first
    localparam int M_IO   = 0;
    localparam int M_IN   = M_IO + IO_W;
    localparam int M_ROW  = M_IN + 1;
    localparam int M_COL  = M_ROW + R;
    localparam int M_IDX  = M_COL + C;
    localparam int M_SLOT = M_IDX + IDX_W;
    localparam int M_BC   = M_SLOT + 1;
    localparam int M_SEQ  = M_BC + 1;
    localparam int S_ROW  = 0;
    localparam int S_COL  = S_ROW + R;
    localparam int S_IDX  = S_COL + C;
    localparam int S_ST   = S_IDX + IDX_W;

    localparam logic [COMMAND_WIDTH-1:0] CMD_INSTR  = COMMAND_WIDTH'(0);
    localparam logic [COMMAND_WIDTH-1:0] CMD_MAP    = COMMAND_WIDTH'(1);
    localparam logic [COMMAND_WIDTH-1:0] CMD_SIGNAL = COMMAND_WIDTH'(2);

    localparam int PTR_W = (BYPASS_DEPTH > 1) ? $clog2(BYPASS_DEPTH) : 1;
    localparam int CNT_W = $clog2(BYPASS_DEPTH + 1);

    if (BYPASS_DEPTH < 1) begin : g_chk_depth
        $error("nx_msg_router: BYPASS_DEPTH must be at least 1");
    end
    if (COMMAND_WIDTH < 2) begin : g_chk_cmd
        $error("nx_msg_router: COMMAND_WIDTH must be at least 2");
    end
    if (PW < INSTR_BITS || PW < MAP_BITS || PW < SIG_BITS) begin : g_chk_payload
        $error("nx_msg_router: a payload format does not fit in the message");
    end

    // Coordinates are compared as two's-complement values, so a target at
    // column 0xF lies west of column 3 while column 4 lies east of it.
    function automatic logic [1:0] route_dir(
        input logic [R-1:0] t_row, input logic [C-1:0] t_col,
        input logic [R-1:0] n_row, input logic [C-1:0] n_col);
        logic [1:0] dir;
        if ($signed(t_row) < $signed(n_row))      dir = 2'd0;
        else if ($signed(t_row) > $signed(n_row)) dir = 2'd2;
        else if ($signed(t_col) > $signed(n_col)) dir = 2'd1;
        else                                      dir = 2'd3;
        return dir;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BYPASS_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [R-1:0]             tgt_row;
    logic [C-1:0]             tgt_col;
    logic [COMMAND_WIDTH-1:0] cmd;
    logic                     is_local;
    logic                     accept;
    logic                     push;
    logic                     pop;
    logic                     unused_msg_bits;

    assign tgt_row  = msg_data_i[STREAM_WIDTH-1 -: R];
    assign tgt_col  = msg_data_i[STREAM_WIDTH-R-1 -: C];
    assign cmd      = msg_data_i[STREAM_WIDTH-R-C-1 -: COMMAND_WIDTH];
    assign is_local = (tgt_row == node_row_i) && (tgt_col == node_col_i);
    // Payload bits above the widest format are intentionally ignored
    assign unused_msg_bits = ^msg_data_i;

    // Bypass FIFO
    logic [STREAM_WIDTH-1:0] fifo_data_q [BYPASS_DEPTH];
    logic [1:0]              fifo_dir_q  [BYPASS_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;

    assign msg_ready_o    = (count_q < CNT_W'(BYPASS_DEPTH));
    assign accept         = msg_valid_i && msg_ready_o;
    assign push           = accept && !is_local;
    assign bypass_valid_o = (count_q != '0);
    assign pop            = bypass_valid_o && bypass_ready_i;
    assign bypass_data_o  = bypass_valid_o ? fifo_data_q[rd_ptr_q] : '0;
    assign bypass_dir_o   = bypass_valid_o ? fifo_dir_q[rd_ptr_q]  : 2'd0;

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= msg_data_i;
            fifo_dir_q[wr_ptr_q]  <= route_dir(tgt_row, tgt_col, node_row_i, node_col_i);
        end
    end

    // Local decode
    logic [IO_W-1:0]        map_io_q, map_io_d;
    logic                   map_input_q, map_input_d;
    logic [R-1:0]           map_row_q, map_row_d;
    logic [C-1:0]           map_col_q, map_col_d;
    logic [IDX_W-1:0]       map_idx_q, map_idx_d;
    logic                   map_slot_q, map_slot_d;
    logic                   map_bc_q, map_bc_d;
    logic                   map_seq_q, map_seq_d;
    logic                   map_valid_q, map_valid_d;
    logic [R-1:0]           sig_row_q, sig_row_d;
    logic [C-1:0]           sig_col_q, sig_col_d;
    logic [IDX_W-1:0]       sig_idx_q, sig_idx_d;
    logic                   sig_state_q, sig_state_d;
    logic                   sig_valid_q, sig_valid_d;
    logic [CORE_W-1:0]      instr_core_q, instr_core_d;
    logic [INSTR_WIDTH-1:0] instr_data_q, instr_data_d;
    logic                   instr_valid_q, instr_valid_d;
    logic [7:0]             drop_count_q, drop_count_d;

    always_comb begin
        map_io_d      = map_io_q;
        map_input_d   = map_input_q;
        map_row_d     = map_row_q;
        map_col_d     = map_col_q;
        map_idx_d     = map_idx_q;
        map_slot_d    = map_slot_q;
        map_bc_d      = map_bc_q;
        map_seq_d     = map_seq_q;
        map_valid_d   = 1'b0;
        sig_row_d     = sig_row_q;
        sig_col_d     = sig_col_q;
        sig_idx_d     = sig_idx_q;
        sig_state_d   = sig_state_q;
        sig_valid_d   = 1'b0;
        instr_core_d  = instr_core_q;
        instr_data_d  = instr_data_q;
        instr_valid_d = 1'b0;
        drop_count_d  = drop_count_q;
        if (accept && is_local) begin
            if (cmd == CMD_INSTR) begin
                instr_core_d  = msg_data_i[0 +: CORE_W];
                instr_data_d  = msg_data_i[CORE_W +: INSTR_WIDTH];
                instr_valid_d = 1'b1;
            end else if (cmd == CMD_MAP) begin
                map_io_d    = msg_data_i[M_IO +: IO_W];
                map_input_d = msg_data_i[M_IN];
                map_row_d   = msg_data_i[M_ROW +: R];
                map_col_d   = msg_data_i[M_COL +: C];
                map_idx_d   = msg_data_i[M_IDX +: IDX_W];
                map_slot_d  = msg_data_i[M_SLOT];
                map_bc_d    = msg_data_i[M_BC];
                map_seq_d   = msg_data_i[M_SEQ];
                map_valid_d = 1'b1;
            end else if (cmd == CMD_SIGNAL) begin
                sig_row_d   = msg_data_i[S_ROW +: R];
                sig_col_d   = msg_data_i[S_COL +: C];
                sig_idx_d   = msg_data_i[S_IDX +: IDX_W];
                sig_state_d = msg_data_i[S_ST];
                sig_valid_d = 1'b1;
            end else if (drop_count_q != 8'hFF) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end
    end

    // Reset clears every visible output, including held decode fields
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            map_io_q      <= '0;
            map_input_q   <= 1'b0;
            map_row_q     <= '0;
            map_col_q     <= '0;
            map_idx_q     <= '0;
            map_slot_q    <= 1'b0;
            map_bc_q      <= 1'b0;
            map_seq_q     <= 1'b0;
            map_valid_q   <= 1'b0;
            sig_row_q     <= '0;
            sig_col_q     <= '0;
            sig_idx_q     <= '0;
            sig_state_q   <= 1'b0;
            sig_valid_q   <= 1'b0;
            instr_core_q  <= '0;
            instr_data_q  <= '0;
            instr_valid_q <= 1'b0;
            drop_count_q  <= 8'd0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            map_io_q      <= map_io_d;
            map_input_q   <= map_input_d;
            map_row_q     <= map_row_d;
            map_col_q     <= map_col_d;
            map_idx_q     <= map_idx_d;
            map_slot_q    <= map_slot_d;
            map_bc_q      <= map_bc_d;
            map_seq_q     <= map_seq_d;
            map_valid_q   <= map_valid_d;
            sig_row_q     <= sig_row_d;
            sig_col_q     <= sig_col_d;
            sig_idx_q     <= sig_idx_d;
            sig_state_q   <= sig_state_d;
            sig_valid_q   <= sig_valid_d;
            instr_core_q  <= instr_core_d;
            instr_data_q  <= instr_data_d;
            instr_valid_q <= instr_valid_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign map_io_o            = map_io_q;
    assign map_input_o         = map_input_q;
    assign map_remote_row_o    = map_row_q;
    assign map_remote_col_o    = map_col_q;
    assign map_remote_idx_o    = map_idx_q;
    assign map_slot_o          = map_slot_q;
    assign map_broadcast_o     = map_bc_q;
    assign map_seq_o           = map_seq_q;
    assign map_valid_o         = map_valid_q;
    assign signal_remote_row_o = sig_row_q;
    assign signal_remote_col_o = sig_col_q;
    assign signal_remote_idx_o = sig_idx_q;
    assign signal_state_o      = sig_state_q;
    assign signal_valid_o      = sig_valid_q;
    assign instr_core_o        = instr_core_q;
    assign instr_data_o        = instr_data_q;
    assign instr_valid_o       = instr_valid_q;
    assign drop_count_o        = drop_count_q;

endmodule

// File: tb/tb_nx_msg_router.sv
module tb_nx_msg_router;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  node_row, node_col;
    logic [31:0] msg_data;
    logic        msg_valid, msg_ready;
    logic [31:0] bypass_data;
    logic [1:0]  bypass_dir;
    logic        bypass_valid, bypass_ready;
    logic [2:0]  map_io;
    logic        map_input;
    logic [3:0]  map_row, map_col;
    logic [2:0]  map_idx;
    logic        map_slot, map_bc, map_seq, map_valid;
    logic [3:0]  sig_row, sig_col;
    logic [2:0]  sig_idx;
    logic        sig_state, sig_valid;
    logic [0:0]  instr_core;
    logic [14:0] instr_data;
    logic        instr_valid;
    logic [7:0]  drop_count;

    nx_msg_router dut (
        .clk_i(clk), .rst_i(rst), .node_row_i(node_row), .node_col_i(node_col),
        .msg_data_i(msg_data), .msg_valid_i(msg_valid), .msg_ready_o(msg_ready),
        .bypass_data_o(bypass_data), .bypass_dir_o(bypass_dir),
        .bypass_valid_o(bypass_valid), .bypass_ready_i(bypass_ready),
        .map_io_o(map_io), .map_input_o(map_input), .map_remote_row_o(map_row),
        .map_remote_col_o(map_col), .map_remote_idx_o(map_idx), .map_slot_o(map_slot),
        .map_broadcast_o(map_bc), .map_seq_o(map_seq), .map_valid_o(map_valid),
        .signal_remote_row_o(sig_row), .signal_remote_col_o(sig_col),
        .signal_remote_idx_o(sig_idx), .signal_state_o(sig_state),
        .signal_valid_o(sig_valid), .instr_core_o(instr_core),
        .instr_data_o(instr_data), .instr_valid_o(instr_valid),
        .drop_count_o(drop_count)
    );

    // Reference model state
    typedef struct {
        logic [31:0] data;
        int          dir;
    } bent_t;
    bent_t bq[$];
    int e_iv, e_core, e_instr;
    int e_mv, e_io, e_min, e_mrow, e_mcol, e_midx, e_slot, e_bc, e_seq;
    int e_sv, e_srow, e_scol, e_sidx, e_sst;
    int e_drop;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int s4(input int x);
        return (x >= 8) ? x - 16 : x;
    endfunction

    function automatic int field(input logic [31:0] d, input int off, input int w);
        return int'((d >> off) & ((32'd1 << w) - 32'd1));
    endfunction

    function automatic int dir_of(input int tr, input int tc);
        if (s4(tr) < s4(int'(node_row))) return 0;
        if (s4(tr) > s4(int'(node_row))) return 2;
        if (s4(tc) > s4(int'(node_col))) return 1;
        return 3;
    endfunction

    task automatic model_clear();
        bq.delete();
        {e_iv, e_core, e_instr} = '0;
        {e_mv, e_io, e_min, e_mrow, e_mcol, e_midx, e_slot, e_bc, e_seq} = '0;
        {e_sv, e_srow, e_scol, e_sidx, e_sst} = '0;
        e_drop = 0;
    endtask

    // Effect of one rising edge given the inputs currently applied
    task automatic model_edge();
        bit    pop_now, acc;
        int    tr, tc, cm;
        bent_t ent;
        if (rst) begin
            model_clear();
            return;
        end
        pop_now = (bq.size() > 0) && bypass_ready;
        acc     = msg_valid && (bq.size() < DEPTH);
        e_iv = 0; e_mv = 0; e_sv = 0;
        if (pop_now) void'(bq.pop_front());
        if (acc) begin
            tr = field(msg_data, 28, 4);
            tc = field(msg_data, 24, 4);
            cm = field(msg_data, 22, 2);
            if (tr == int'(node_row) && tc == int'(node_col)) begin
                case (cm)
                    0: begin
                        e_iv = 1; e_core = field(msg_data, 0, 1); e_instr = field(msg_data, 1, 15);
                    end
                    1: begin
                        e_mv = 1;
                        e_io = field(msg_data, 0, 3);   e_min  = field(msg_data, 3, 1);
                        e_mrow = field(msg_data, 4, 4); e_mcol = field(msg_data, 8, 4);
                        e_midx = field(msg_data, 12, 3); e_slot = field(msg_data, 15, 1);
                        e_bc = field(msg_data, 16, 1);  e_seq  = field(msg_data, 17, 1);
                    end
                    2: begin
                        e_sv = 1;
                        e_srow = field(msg_data, 0, 4); e_scol = field(msg_data, 4, 4);
                        e_sidx = field(msg_data, 8, 3); e_sst  = field(msg_data, 11, 1);
                    end
                    default: if (e_drop < 255) e_drop++;
                endcase
            end else begin
                ent.data = msg_data;
                ent.dir  = dir_of(tr, tc);
                bq.push_back(ent);
            end
        end
    endtask

    task automatic compare_all();
        check("msg_ready", msg_ready, bq.size() < DEPTH);
        check("bypass_valid", bypass_valid, bq.size() > 0);
        if (bq.size() > 0) begin
            check("bypass_data", bypass_data, bq[0].data);
            check("bypass_dir", bypass_dir, bq[0].dir);
        end
        check("instr_valid", instr_valid, e_iv);
        check("instr_core", instr_core, e_core);
        check("instr_data", instr_data, e_instr);
        check("map_valid", map_valid, e_mv);
        check("map_fields", {map_io, map_input, map_row, map_col, map_idx, map_slot, map_bc, map_seq},
              {3'(e_io), 1'(e_min), 4'(e_mrow), 4'(e_mcol), 3'(e_midx), 1'(e_slot), 1'(e_bc), 1'(e_seq)});
        check("signal_valid", sig_valid, e_sv);
        check("signal_fields", {sig_row, sig_col, sig_idx, sig_state},
              {4'(e_srow), 4'(e_scol), 3'(e_sidx), 1'(e_sst)});
        check("drop_count", drop_count, e_drop);
        check("one_valid", 32'(instr_valid) + 32'(map_valid) + 32'(sig_valid) <= 1, 1);
    endtask

    // Inputs are applied at the falling edge; outputs are checked at the next falling edge
    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input logic [31:0] d);
        msg_valid = 1'b1;
        msg_data  = d;
        cycle();
        msg_valid = 1'b0;
    endtask

    logic [31:0] got[$];
    logic [31:0] b3[3];
    int          idx;
    logic [3:0]  rr, cc;

    initial begin
        node_row = 4'd2; node_col = 4'd3;
        rst = 1'b1; msg_valid = 1'b0; msg_data = '0; bypass_ready = 1'b1;
        model_clear();
        cycle();
        cycle();
        rst = 1'b0;
        check("rst_ready", msg_ready, 1);
        check("rst_drop", drop_count, 0);
        check("rst_instr_data", instr_data, 0);

        // INSTR decode
        send(32'h23000A4B);
        check("instr_lit_valid", instr_valid, 1);
        check("instr_lit_core", instr_core, 1);
        check("instr_lit_data", instr_data, 15'h525);
        check("instr_lit_others", {map_valid, sig_valid, bypass_valid}, 0);
        cycle();
        check("instr_pulse_end", instr_valid, 0);
        check("instr_hold", instr_data, 15'h525);

        // SIGNAL decode
        send(32'h23800A51);
        check("sig_lit", {sig_valid, sig_row, sig_col, sig_idx, sig_state},
              {1'b1, 4'd1, 4'd5, 3'd2, 1'b1});

        // Bypass directions
        send(32'h53001234);
        check("byp_lit_s", {bypass_valid, bypass_data, bypass_dir}, {1'b1, 32'h53001234, 2'd2});
        send(32'h2F000000);
        check("byp_lit_w", {bypass_valid, bypass_data, bypass_dir}, {1'b1, 32'h2F000000, 2'd3});
        send(32'h24000000);
        check("byp_lit_e", {bypass_valid, bypass_data, bypass_dir}, {1'b1, 32'h24000000, 2'd1});
        cycle();

        // Backpressure: three bypass messages, sink stalled
        b3[0] = 32'h53000001; b3[1] = 32'h53000002; b3[2] = 32'h53000003;
        bypass_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 5; k++) begin
            bit will;
            msg_valid = (idx < 3);
            msg_data  = b3[idx % 3];
            will = msg_valid && (bq.size() < DEPTH);
            cycle();
            if (will) idx++;
        end
        check("bp_ready_low", msg_ready, 0);
        check("bp_valid", bypass_valid, 1);
        bypass_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bit will;
            if (bypass_valid) got.push_back(bypass_data);
            msg_valid = (idx < 3);
            msg_data  = b3[idx % 3];
            will = msg_valid && (bq.size() < DEPTH);
            cycle();
            if (will) idx++;
        end
        msg_valid = 1'b0;
        check("bp_count", got.size(), 3);
        for (int k = 0; k < 3; k++) check("bp_order", (k < got.size()) ? got[k] : 32'hX, 32'h53000001 + k);
        check("bp_ready_back", msg_ready, 1);
        check("bp_empty", bypass_valid, 0);

        // Reserved command saturation
        msg_valid = 1'b1;
        msg_data  = 32'h23C00000;
        for (int k = 0; k < 300; k++) cycle();
        msg_valid = 1'b0;
        cycle();
        check("drop_sat", drop_count, 255);
        check("drop_no_valid", {instr_valid, map_valid, sig_valid, bypass_valid}, 0);

        // Reset with queued bypass traffic and a pending local decode
        bypass_ready = 1'b0;
        send(32'h53000011);
        send(32'h00000022);
        check("pre_rst_queued", {bypass_valid, msg_ready}, 2'b10);
        rst = 1'b1; msg_valid = 1'b1; msg_data = 32'h23000A4B;
        cycle();
        rst = 1'b0; msg_valid = 1'b0;
        check("rst_mid_empty", bypass_valid, 0);
        check("rst_mid_drop", drop_count, 0);
        check("rst_mid_ready", msg_ready, 1);
        check("rst_mid_no_instr", {instr_valid, instr_data}, 0);
        cycle();
        check("rst_mid_no_pulse", instr_valid, 0);

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            rst          = ($urandom_range(0, 299) == 0);
            msg_valid    = ($urandom_range(0, 3) != 0);
            bypass_ready = ($urandom_range(0, 2) != 0);
            rr = ($urandom_range(0, 3) < 2) ? 4'd2 : 4'($urandom_range(0, 15));
            cc = ($urandom_range(0, 3) < 2) ? 4'd3 : 4'($urandom_range(0, 15));
            msg_data = {rr, cc, 2'($urandom_range(0, 3)), 22'($urandom)};
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nx_msg_router.md
NX_MSG_ROUTER -- requirements
Module: nx_msg_router

Interface
REQ-001 Parameter STREAM_WIDTH, default 32: inbound/bypass message width.
REQ-002 Parameter ADDR_ROW_WIDTH, default 4: row address width.
REQ-003 Parameter ADDR_COL_WIDTH, default 4: column address width.
REQ-004 Parameter COMMAND_WIDTH, default 2: command field width.
REQ-005 Parameter INSTR_WIDTH, default 15: instruction width.
REQ-006 Parameters INPUTS and OUTPUTS, defaults 8 and 8; MAX_IO = max(INPUTS, OUTPUTS); CORES, default 2: instruction targets; BYPASS_DEPTH, default 2: bypass FIFO entries, minimum 1.
REQ-007 Ports, in order (name, direction, width, meaning):
- clk_i, in, 1: single clock.
- rst_i, in, 1: reset, synchronous, active-high.
- node_row_i / node_col_i, in, ADDR_ROW_WIDTH / ADDR_COL_WIDTH: node identity.
- msg_data_i, in, STREAM_WIDTH; msg_valid_i, in, 1; msg_ready_o, out, 1: inbound stream.
- bypass_data_o, out, STREAM_WIDTH; bypass_dir_o, out, 2; bypass_valid_o, out, 1; bypass_ready_i, in, 1: outbound stream.
- map_io_o, out, clog2(MAX_IO); map_input_o, out, 1; map_remote_row_o, out, ADDR_ROW_WIDTH; map_remote_col_o, out, ADDR_COL_WIDTH; map_remote_idx_o, out, clog2(OUTPUTS); map_slot_o, map_broadcast_o, map_seq_o, map_valid_o, out, 1 each.
- signal_remote_row_o, signal_remote_col_o, signal_remote_idx_o, out, widths as for map; signal_state_o, signal_valid_o, out, 1 each.
- instr_core_o, out, clog2(CORES) (minimum 1); instr_data_o, out, INSTR_WIDTH; instr_valid_o, out, 1.
- drop_count_o, out, 8: count of dropped messages, saturating.

Function
REQ-008 Header, MSB-first: target row, target col, command; payload = remaining LSBs (PW bits); elaboration SHALL fail if any payload format exceeds PW.
REQ-009 Handshake: a message is accepted when msg_valid_i && msg_ready_o; msg_ready_o = (FIFO occupancy < BYPASS_DEPTH), from registered state only.
REQ-010 Target equal to node_row_i/node_col_i: local decode; otherwise push to bypass FIFO unmodified.
REQ-011 Bypass direction: target row < node -> 0 (N); target row > node -> 2 (S); else target col > node -> 1 (E); else 3 (W); stored alongside the data.
REQ-012 Bypass FIFO: in order; head on bypass_data_o/bypass_dir_o, bypass_valid_o = non-empty; pop on bypass_valid_o && bypass_ready_i; accepted message visible the next cycle; push and pop in the same cycle leave occupancy unchanged.
REQ-013 Local command 0 (INSTR): payload LSB-first = core (clog2(CORES) bits), instr (INSTR_WIDTH).
REQ-014 Local command 1 (MAP): payload LSB-first = io, input, remote row, remote col, remote idx, slot, broadcast, seq.
REQ-015 Local command 2 (SIGNAL): payload LSB-first = remote row, remote col, remote idx, state.
REQ-016 Local command 3 (reserved): message dropped; drop_count_o increments, saturating at 255.
REQ-017 Decoded fields and the matching *_valid_o are registered and appear the cycle after acceptance; valid is a one-cycle pulse; fields hold their last value when valid is low.
REQ-018 Local decode never stalls; msg_ready_o depends on FIFO occupancy only, including for local messages.
REQ-019 At most one of map_valid_o, signal_valid_o and instr_valid_o is high in any cycle.

Reset
REQ-020 rst_i high at a clock edge: FIFO emptied, all *_valid_o = 0, all data outputs = 0, drop_count_o = 0; msg_ready_o = 1 from the first cycle after reset.
REQ-021 Reset mid-operation discards queued bypass messages and any decode pending in that cycle; no valid pulse follows.

Verification (defaults; node row 2, col 3)
REQ-022 0x23000A4B accepted -> next cycle instr_valid_o=1, instr_core_o=1, instr_data_o=0x525; no other valid.
REQ-023 0x23800A51 -> next cycle signal_valid_o=1, row=1, col=5, idx=2, state=1.
REQ-024 0x53001234 -> next cycle bypass_valid_o=1, bypass_data_o=0x53001234, bypass_dir_o=2; 0x2F000000 -> dir 3; 0x24000000 -> dir 1.
REQ-025 bypass_ready_i=0, three bypass messages offered back-to-back -> msg_ready_o=0 after two accepts; set bypass_ready_i=1 -> all three emerge in order, msg_ready_o returns to 1.
REQ-026 0x23C00000 sent 300 times -> no valids, no bypass, drop_count_o=255; rst_i pulsed with two messages queued -> FIFO empty, drop_count_o=0.
